// File: rtl/reg_writeback_unit_if.sv
// Channel bundle between the ALU/load producers, the writeback FIFO and the
// register file write port.
interface reg_writeback_unit_if #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 3
);
    logic                     alu_valid;
    logic [DATA_W-1:0]        alu_data;
    logic [ADDR_W-1:0]        alu_dest;
    logic                     alu_ready;

    logic                     mem_valid;
    logic [DATA_W-1:0]        mem_data;
    logic [ADDR_W-1:0]        mem_dest;
    logic                     mem_ready;

    logic [DATA_W-1:0]        data_write;
    logic [ADDR_W-1:0]        data_write_address;
    logic                     reg_write_enable;
    logic [(1<<ADDR_W)-1:0]   pending;
    logic                     wb_empty;
    logic                     wb_full;

    modport slave (
        input  alu_valid, alu_data, alu_dest,
        input  mem_valid, mem_data, mem_dest,
        output alu_ready, mem_ready,
        output data_write, data_write_address, reg_write_enable,
        output pending, wb_empty, wb_full
    );

    modport master (
        output alu_valid, alu_data, alu_dest,
        output mem_valid, mem_data, mem_dest,
        input  alu_ready, mem_ready,
        input  data_write, data_write_address, reg_write_enable,
        input  pending, wb_empty, wb_full
    );
endinterface

// File: rtl/reg_writeback_unit.sv
// Writeback buffer: merges ALU and load results into an in-order FIFO and
// issues at most one register file write per cycle, with a RAW pending map.
module reg_writeback_unit #(
    parameter int DEPTH  = 4,
    parameter int DATA_W = 16,
    parameter int ADDR_W = 3
) (
    input  logic                  clock,
    input  logic                  reset,
    reg_writeback_unit_if.slave   wb
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int NREG  = 1 << ADDR_W;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic [ADDR_W-1:0] dest;
    } entry_t;

    entry_t              r_mem [DEPTH];
    logic [PTR_W-1:0]    r_wr_ptr;
    logic [PTR_W-1:0]    r_rd_ptr;
    logic [CNT_W-1:0]    r_count;
    logic                r_we;
    logic [DATA_W-1:0]   r_data;
    logic [ADDR_W-1:0]   r_addr;

    logic [CNT_W-1:0]    w_free;
    logic                w_mem_ready;
    logic                w_alu_ready;
    logic                w_push_mem;
    logic                w_push_alu;
    logic                w_pop;
    logic [CNT_W-1:0]    w_n_push;
    logic [PTR_W-1:0]    w_alu_slot;
    entry_t              w_head;
    logic [NREG-1:0]     w_pending;

    // Space is judged on the start-of-cycle count; a same-cycle pop never
    // makes room for that cycle's pushes.
    assign w_free      = FULL_CNT - r_count;
    assign w_mem_ready = (w_free != '0);
    assign w_alu_ready = (w_free >= CNT_W'(2)) | ((w_free != '0) & ~wb.mem_valid);

    assign w_push_mem  = wb.mem_valid & w_mem_ready;
    assign w_push_alu  = wb.alu_valid & w_alu_ready;
    assign w_pop       = (r_count != '0);
    assign w_n_push    = CNT_W'(w_push_mem) + CNT_W'(w_push_alu);
    assign w_alu_slot  = r_wr_ptr + PTR_W'(w_push_mem);
    assign w_head      = r_mem[r_rd_ptr];

    // NOTE: FIFO storage has no reset; an entry is only observed once count
    // covers it, so clearing the array would cost area for no behaviour.
    always_ff @(posedge clock) begin
        if (w_push_mem) r_mem[r_wr_ptr]   <= '{data: wb.mem_data, dest: wb.mem_dest};
        if (w_push_alu) r_mem[w_alu_slot] <= '{data: wb.alu_data, dest: wb.alu_dest};
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // here sees the pre-edge values of the others.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_we     <= 1'b0;
            r_data   <= '0;
            r_addr   <= '0;
        end else begin
            r_wr_ptr <= r_wr_ptr + PTR_W'(w_n_push);
            r_count  <= r_count + w_n_push - CNT_W'(w_pop);
            r_we     <= w_pop;
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
                r_data   <= w_head.data;
                r_addr   <= w_head.dest;
            end
        end
    end

    // An entry is live when its distance from the head is below count.
    always_comb begin
        w_pending = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if ({1'b0, PTR_W'(i) - r_rd_ptr} < r_count)
                w_pending[r_mem[i].dest] = 1'b1;
        end
        if (r_we)
            w_pending[r_addr] = 1'b1;
    end

    assign wb.alu_ready          = w_alu_ready;
    assign wb.mem_ready          = w_mem_ready;
    assign wb.data_write         = r_data;
    assign wb.data_write_address = r_addr;
    assign wb.reg_write_enable   = r_we;
    assign wb.pending            = w_pending;
    assign wb.wb_empty           = (r_count == '0) & ~r_we;
    assign wb.wb_full            = (r_count == FULL_CNT);
endmodule
